servo_360_quartos: RTL and testbench

SERVO_360_QUARTOS -- requirements
Module: servo_360_quartos

---
 rtl/servo_360_pkg.sv | 21 ++
 rtl/servo_360_pwm.sv | 45 ++++
 rtl/servo_360_quartos.sv | 132 +++++++++++++
 tb/tb_servo_360_quartos.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/servo_360_pkg.sv
// Shared state encoding and default timing for the quarter-turn servo driver.
// Optional brake (FREIA state) is enabled by defining SERVO_360_FREIO_EN.
package servo_360_pkg;

   typedef enum logic [2:0] {
      INICIAL = 3'd0,
      PREPARA = 3'd1,
      GIRA    = 3'd2,
      FREIA   = 3'd3,
      FIM     = 3'd4
   } estado_t;

   // Defaults assume a 50 MHz clock and a 20 ms servo frame.
   localparam int unsigned PERIODO_PWM_DEF    = 1_000_000;
   localparam int unsigned LARGURA_HOR_DEF    = 65_000;
   localparam int unsigned LARGURA_ANTI_DEF   = 85_000;
   localparam int unsigned LARGURA_NEUTRO_DEF = 75_000;
   localparam int unsigned CICLOS_QUARTO_DEF  = 12_500_000;
   localparam int unsigned CICLOS_FREIO_DEF   = 5_000_000;

endpackage

// File: rtl/servo_360_pwm.sv
// PWM frame generator: free-running period counter plus width comparator.
// Output is registered and already reflects the counter value it will show next cycle.
module servo_360_pwm #(
   parameter int unsigned PERIODO_PWM = 1_000_000,
   parameter int unsigned PW          = $clog2(PERIODO_PWM + 1)
) (
   input  logic          clock_i,
   input  logic          reset_i,
   input  logic          clear_i,
   input  logic          enable_i,
   input  logic [PW-1:0] width_i,
   output logic          pwm_o
);

   logic [PW-1:0] cnt_q, cnt_d, prox;
   logic          pwm_q, pwm_d;

   assign prox = (cnt_q == PW'(PERIODO_PWM - 1)) ? '0 : cnt_q + PW'(1);

   // clear places the counter at phase 0 for the first enabled cycle
   always_comb begin
      cnt_d = cnt_q;
      pwm_d = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
         pwm_d = enable_i && (width_i != '0);
      end else if (enable_i) begin
         cnt_d = prox;
         pwm_d = (prox < width_i);
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pwm_q <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_360_quartos.sv
// Continuous-rotation servo driver turning 0..3 quarter turns per request.
// Define SERVO_360_FREIO_EN to add a neutral-pulse brake phase (FREIA) after the turn.
module servo_360_quartos
   import servo_360_pkg::*;
#(
   parameter int unsigned PERIODO_PWM    = PERIODO_PWM_DEF,
   parameter int unsigned LARGURA_HOR    = LARGURA_HOR_DEF,
   parameter int unsigned LARGURA_ANTI   = LARGURA_ANTI_DEF,
   parameter int unsigned LARGURA_NEUTRO = LARGURA_NEUTRO_DEF,
   parameter int unsigned CICLOS_QUARTO  = CICLOS_QUARTO_DEF,
   parameter int unsigned CICLOS_FREIO   = CICLOS_FREIO_DEF
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       sentido,
   input  logic [1:0] quartos,
   output logic       pwm,
   output logic       ocupado,
   output logic       pronto,
   output logic [2:0] db_estado
);

   localparam int unsigned TW = $clog2(3 * CICLOS_QUARTO + 1);
   localparam int unsigned PW = $clog2(PERIODO_PWM + 1);

   estado_t       estado_q, estado_d;
   logic          sentido_q;
   logic [1:0]    quartos_q;
   logic [TW-1:0] giro_q, giro_d, alvo;
   logic          fim_giro;
   logic          pronto_q, pronto_d;
   logic          pwm_limpa, pwm_habilita;
   logic [PW-1:0] pwm_largura;

   assign alvo     = TW'(quartos_q) * TW'(CICLOS_QUARTO);
   assign fim_giro = (giro_q == alvo - TW'(1));

`ifdef SERVO_360_FREIO_EN
   localparam int unsigned FW = $clog2(CICLOS_FREIO + 1);
   logic [FW-1:0] freio_q, freio_d;
   logic          fim_freio;

   assign fim_freio = (freio_q == FW'(CICLOS_FREIO - 1));
   assign freio_d   = (estado_q == FREIA) ? freio_q + FW'(1) : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) freio_q <= '0;
      else       freio_q <= freio_d;
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) estado_q <= INICIAL;
      else       estado_q <= estado_d;
   end

   always_comb begin
      estado_d = estado_q;
      case (estado_q)
         INICIAL: if (iniciar) estado_d = PREPARA;
         PREPARA: estado_d = (quartos_q != 2'd0) ? GIRA : FIM;
         GIRA: begin
            if (fim_giro) begin
`ifdef SERVO_360_FREIO_EN
               estado_d = FREIA;
`else
               estado_d = FIM;
`endif
            end
         end
`ifdef SERVO_360_FREIO_EN
         FREIA:   if (fim_freio) estado_d = FIM;
`endif
         FIM:     estado_d = INICIAL;
         default: estado_d = INICIAL;
      endcase
   end

   always_comb begin
      giro_d = giro_q;
      if (estado_q == PREPARA)   giro_d = '0;
      else if (estado_q == GIRA) giro_d = giro_q + TW'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sentido_q <= 1'b0;
         quartos_q <= '0;
         giro_q    <= '0;
         pronto_q  <= 1'b0;
      end else begin
         if (estado_q == INICIAL && iniciar) begin
            sentido_q <= sentido;
            quartos_q <= quartos;
         end
         giro_q   <= giro_d;
         pronto_q <= pronto_d;
      end
   end

   // PWM controls look at the next state so the registered pwm lines up with GIRA/FREIA
   always_comb begin
      ocupado      = (estado_q != INICIAL);
      db_estado    = estado_q;
      pronto_d     = (estado_d == FIM);
      pwm_limpa    = (estado_q == PREPARA);
      pwm_habilita = (estado_d == GIRA);
`ifdef SERVO_360_FREIO_EN
      pwm_habilita = pwm_habilita || (estado_d == FREIA);
`endif
      if (estado_d == GIRA)
         pwm_largura = sentido_q ? PW'(LARGURA_ANTI) : PW'(LARGURA_HOR);
      else
         pwm_largura = PW'(LARGURA_NEUTRO);
   end

   servo_360_pwm #(
      .PERIODO_PWM (PERIODO_PWM),
      .PW          (PW)
   ) u_pwm (
      .clock_i  (clock),
      .reset_i  (reset),
      .clear_i  (pwm_limpa),
      .enable_i (pwm_habilita),
      .width_i  (pwm_largura),
      .pwm_o    (pwm)
   );

   assign pronto = pronto_q;

endmodule

// File: tb/tb_servo_360_quartos.sv
// Bench for servo_360_quartos: schedule-based reference model plus literal per-operation checks.
// Follows SERVO_360_FREIO_EN the same way as the design.
module tb_servo_360_quartos;

   localparam int PER   = 20;
   localparam int HOR   = 3;
   localparam int ANTI  = 7;
   localparam int NEU   = 5;
   localparam int QUA   = 40;
`ifdef SERVO_360_FREIO_EN
   localparam int FC    = 20;
`else
   localparam int FC    = 0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       iniciar = 1'b0;
   logic       sentido = 1'b0;
   logic [1:0] quartos = 2'd0;
   logic       pwm, ocupado, pronto;
   logic [2:0] db_estado;

   int n_vec = 0;
   int n_err = 0;

   servo_360_quartos #(
      .PERIODO_PWM    (PER),
      .LARGURA_HOR    (HOR),
      .LARGURA_ANTI   (ANTI),
      .LARGURA_NEUTRO (NEU),
      .CICLOS_QUARTO  (QUA),
      .CICLOS_FREIO   (20)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .iniciar   (iniciar),
      .sentido   (sentido),
      .quartos   (quartos),
      .pwm       (pwm),
      .ocupado   (ocupado),
      .pronto    (pronto),
      .db_estado (db_estado)
   );

   always #5 clock = ~clock;

   task automatic check(input string nome, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
      end
   endtask

   // Model: an accepted request opens a timeline k = 0 (prepare), 1..G (turn),
   // G+1..G+FC (brake), G+FC+1 (done); phase within the PWM frame is k-1.
   bit m_act = 1'b0;
   int m_k   = 0;
   int m_q   = 0;
   bit m_s   = 1'b0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_act = 1'b0;
      end else if (m_act) begin
         if (m_k >= m_q * QUA + FC + 1) m_act = 1'b0;
         else                           m_k++;
      end else if (iniciar) begin
         m_act = 1'b1;
         m_k   = 0;
         m_q   = int'(quartos);
         m_s   = sentido;
      end
   end

   always @(negedge clock) begin
      int est, p, pr, g;
      if (!reset) begin
         g = m_q * QUA;
         est = 0; p = 0; pr = 0;
         if (m_act) begin
            if (m_k == 0) est = 1;
            else if (m_k <= g) begin
               est = 2;
               p = (((m_k - 1) % PER) < (m_s ? ANTI : HOR)) ? 1 : 0;
            end else if (m_k <= g + FC) begin
               est = 3;
               p = (((m_k - 1) % PER) < NEU) ? 1 : 0;
            end else begin
               est = 4;
               pr = 1;
            end
         end
         check("db_estado", int'(db_estado), est);
         check("pwm", int'(pwm), p);
         check("pronto", int'(pronto), pr);
         check("ocupado", int'(ocupado), (est != 0) ? 1 : 0);
      end
   end

   // Runs one request while scrambling inputs; iniciar cycle counts as cycle 1.
   task automatic run_op(input bit s, input int q, input int exp_c, input int exp_g,
                         input int exp_gh, input int exp_f, input int exp_fh);
      int c, g, gh, f, fh, oc;
      bit done;
      c = 1; g = 0; gh = 0; f = 0; fh = 0; oc = 0; done = 1'b0;
      @(posedge clock); #2;
      sentido = s; quartos = 2'(q); iniciar = 1'b1;
      while (!done && c < 400) begin
         @(posedge clock); #2;
         iniciar = 1'($urandom); sentido = 1'($urandom); quartos = 2'($urandom);
         c++;
         @(negedge clock);
         if (db_estado == 3'd2) begin g++; if (pwm) gh++; end
         if (db_estado == 3'd3) begin f++; if (pwm) fh++; end
         if (ocupado) oc++;
         if (pronto) done = 1'b1;
      end
      check("ciclo_pronto", c, exp_c);
      check("ciclos_gira", g, exp_g);
      check("altos_gira", gh, exp_gh);
      check("ciclos_freia", f, exp_f);
      check("altos_freia", fh, exp_fh);
      check("ciclos_ocupado", oc, exp_c - 1);
      @(posedge clock); #2;
      iniciar = 1'b0;
   endtask

   initial begin
      int found, cyc, q;
      bit s;
      repeat (2) @(posedge clock);
      #1;
      check("reset_estado", int'(db_estado), 0);
      check("reset_pwm", int'(pwm), 0);
      check("reset_pronto", int'(pronto), 0);
      check("reset_ocupado", int'(ocupado), 0);
      #1 reset = 1'b0;
      repeat (2) @(posedge clock);

      run_op(1'b0, 1, 43 + FC, 40, 6, FC, (FC != 0) ? 5 : 0);
      run_op(1'b1, 3, 123 + FC, 120, 42, FC, (FC != 0) ? 5 : 0);
      run_op(1'b0, 0, 3, 0, 0, 0, 0);
      run_op(1'b1, 2, 83 + FC, 80, 28, FC, (FC != 0) ? 5 : 0);

      // reset in the middle of a high pwm pulse inside the turn
      @(posedge clock); #2;
      sentido = 1'b0; quartos = 2'd2; iniciar = 1'b1;
      @(posedge clock); #2;
      iniciar = 1'b0;
      found = 0; cyc = 0;
      while (found == 0 && cyc < 100) begin
         @(negedge clock);
         cyc++;
         if (db_estado == 3'd2 && pwm && cyc > 10) found = 1;
      end
      check("reset_alvo_encontrado", found, 1);
      #1 reset = 1'b1;
      #1;
      check("reset_async_pwm", int'(pwm), 0);
      check("reset_async_estado", int'(db_estado), 0);
      check("reset_async_ocupado", int'(ocupado), 0);
      check("reset_async_pronto", int'(pronto), 0);
      @(posedge clock); #2;
      reset = 1'b0;
      run_op(1'b0, 2, 83 + FC, 80, 12, FC, (FC != 0) ? 5 : 0);

      for (int i = 0; i < 8; i++) begin
         q = int'($urandom_range(0, 3));
         s = 1'($urandom);
         repeat ($urandom_range(0, 3)) @(posedge clock);
         run_op(s, q, 3 + q * QUA + FC, q * QUA, q * 2 * (s ? ANTI : HOR),
                (q != 0) ? FC : 0, (q != 0 && FC != 0) ? 5 : 0);
      end

      repeat (3) @(posedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
